// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit holding the HI/LO pair.
// MULT/MULTU hold busy for 5 cycles and DIV/DIVU for 10; MTHI/MTLO complete in one cycle.
module ex_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        accept;
  logic        mul_signed, div_signed, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, quo, rem;

  assign busy = (cnt_q != 4'd0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  assign accept = start && !cancel && !busy && (md_op <= OP_MTLO);

  // Sign-extending (or zero-extending) to 64 bits lets one multiplier serve both flavours.
  assign mul_signed = (op_q == OP_MULT);
  assign a_ext      = {{32{mul_signed & a_q[31]}}, a_q};
  assign b_ext      = {{32{mul_signed & b_q[31]}}, b_q};
  assign prod       = a_ext * b_ext;

  // Signed divide runs on magnitudes, so 0x80000000 / -1 yields 0x80000000 without overflow.
  assign div_signed = (op_q == OP_DIV);
  assign a_neg      = div_signed & a_q[31];
  assign b_neg      = div_signed & b_q[31];
  assign a_mag      = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag      = b_neg ? (32'd0 - b_q) : b_q;
  assign b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq         = a_mag / b_safe;
  assign ur         = a_mag % b_safe;
  assign quo        = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem        = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (accept) begin
      case (md_op)
        OP_MTHI: hi_d = rs_e;
        OP_MTLO: lo_d = rs_e;
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          a_d   = rs_e;
          b_d   = rt_e;
          op_d  = md_op;
          cnt_d = (md_op == OP_DIV || md_op == OP_DIVU) ? DIV_CYCLES : MULT_CYCLES;
        end
        default: ;
      endcase
    end else if (busy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        if (op_q == OP_MULT || op_q == OP_MULTU) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (b_q != 32'd0) begin
          hi_d = rem;
          lo_d = quo;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed vector table, random ops against an
// arithmetic reference model, and hand-written busy/cancel/reset sequences.
module tb_ex_mdu;

  logic        clk, reset, start, cancel, busy;
  logic [2:0]  md_op;
  logic [31:0] rs_e, rt_e, hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          cyc;
  } vec_t;
  vec_t tbl[10];

  ex_mdu dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .cancel(cancel),
    .rs_e(rs_e), .rt_e(rt_e), .busy(busy), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic straight from the operation definitions.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] h_in, input logic [31:0] l_in,
                                 output logic [31:0] h, output logic [31:0] l, output int cyc);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    h = h_in; l = l_in; cyc = 0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a) & 64'hFFFF_FFFF; ub = longint'(b) & 64'hFFFF_FFFF;
    case (op)
      3'd0: begin sq = sa * sb; h = sq[63:32]; l = sq[31:0]; cyc = 5; end
      3'd1: begin up = ua * ub; h = up[63:32]; l = up[31:0]; cyc = 5; end
      3'd2: begin
        cyc = 10;
        if (b != 0) begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
      end
      3'd3: begin
        cyc = 10;
        if (b != 0) begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cn, input logic [31:0] ehi,
                       input logic [31:0] elo, input int ecyc);
    logic [31:0] hi0, lo0;
    logic held;
    int n;
    hi0 = hi; lo0 = lo; held = 1'b1;
    md_op = op; rs_e = a; rt_e = b; cancel = cn; start = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0; rs_e = $urandom; rt_e = $urandom;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      step();
    end
    check({nm, "_cycles"}, 32'(n), 32'(ecyc));
    if (ecyc > 0) check({nm, "_held"}, {31'd0, held}, 32'd1);
    check({nm, "_hi"}, hi, ehi);
    check({nm, "_lo"}, lo, elo);
    mhi = ehi; mlo = elo;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    logic        cn, flag;
    int          cyc, n;

    tbl[0] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    tbl[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[4] = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h80000000, 0};
    tbl[5] = '{3'd5, 32'h12345678, 32'd0,        32'h12345678, 32'h12345678, 0};
    tbl[6] = '{3'd3, 32'd7,        32'd0,        32'h12345678, 32'h12345678, 10};
    tbl[7] = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    tbl[8] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    tbl[9] = '{3'd6, 32'hDEADBEEF, 32'd3,        32'h00000001, 32'hFFFFFFFD, 0};

    start = 1'b0; cancel = 1'b0; md_op = 3'd0; rs_e = '0; rt_e = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    step(); step();
    reset = 1'b1;

    // First vector is issued at the first edge after reset release.
    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 1'b0,
            tbl[i].ehi, tbl[i].elo, tbl[i].cyc);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i % 5 == 0) b = 32'($urandom_range(1, 9));
      cn = ($urandom_range(0, 3) == 0);
      if (!cn) ref_op(op, a, b, mhi, mlo, eh, el, cyc);
      else begin eh = mhi; el = mlo; cyc = 0; end
      do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, cn, eh, el, cyc);
    end

    // MTHI then MTLO back to back, then a cancelled MTLO.
    flag = 1'b0;
    md_op = 3'd4; rs_e = 32'hAAAA5555; start = 1'b1;
    step();
    flag = flag | busy;
    check("mthi_hi", hi, 32'hAAAA5555);
    md_op = 3'd5; rs_e = 32'h0000BEEF;
    step();
    flag = flag | busy;
    check("mtlo_lo", lo, 32'h0000BEEF);
    check("mtlo_hi", hi, 32'hAAAA5555);
    md_op = 3'd5; rs_e = 32'hDEADDEAD; cancel = 1'b1;
    step();
    flag = flag | busy;
    start = 1'b0; cancel = 1'b0;
    check("mtlo_cancel_lo", lo, 32'h0000BEEF);
    check("mt_never_busy", {31'd0, flag}, 32'd0);

    // DIV with an ignored MULT request and a cancel pulse mid-busy.
    md_op = 3'd2; rs_e = 32'd100; rt_e = 32'hFFFFFFF9; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      start = (n == 3); md_op = 3'd0; rs_e = 32'd3; rt_e = 32'd4; cancel = (n == 5);
      step();
    end
    start = 1'b0; cancel = 1'b0;
    check("div_ignore_cycles", 32'(n), 32'd10);
    check("div_ignore_hi", hi, 32'h00000002);
    check("div_ignore_lo", lo, 32'hFFFFFFF2);
    step();
    check("div_ignore_idle", {31'd0, busy}, 32'd0);
    check("div_ignore_hold_lo", lo, 32'hFFFFFFF2);
    do_op("mult_reissue", 3'd0, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12, 5);

    // Reset asserted between edges during a MULT aborts it for good.
    md_op = 3'd1; rs_e = 32'hFFFFFFFF; rt_e = 32'd2; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    #3 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    step(); step();
    #2 reset = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) flag = 1'b1;
    end
    check("abort_no_update", {31'd0, flag}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
